wb_dest_scoreboard: RTL

- Parametrised successor to the register-write-address select in the CPU decode path.
- Selects the destination register for each issued instruction: link register, rt, rd, or no write.
- Carries the destination through a LAT-stage write-back delay line and keeps a per-register busy scoreboard.
- Stalls issue on RAW/WAW hazards against in-flight writes. Sits between decode and the register-file write port.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/wb_delay_line.sv | 52 +++++
 rtl/wb_dest_scoreboard.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: destination-mode encodings and default
// geometry of the write-back destination scoreboard.
package cpu_pkg;

    typedef enum logic [1:0] {
        DST_LINK = 2'b00,
        DST_RT   = 2'b01,
        DST_RD   = 2'b10,
        DST_NONE = 2'b11
    } dst_mode_e;

    localparam int unsigned DEFAULT_N        = 3;
    localparam int unsigned DEFAULT_LINK_REG = 7;
    localparam int unsigned DEFAULT_LAT      = 3;

endpackage

// File: rtl/wb_delay_line.sv
// LAT-stage valid+address shift register carrying accepted destinations to
// the register-file write port; stage LAT-1 is the registered output.
module wb_delay_line
    import cpu_pkg::*;
#(
    parameter int unsigned N   = DEFAULT_N,
    parameter int unsigned LAT = DEFAULT_LAT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_addr,
    output logic         out_valid,
    output logic [N-1:0] out_addr
);

    logic         valid_q [LAT];
    logic         valid_d [LAT];
    logic [N-1:0] addr_q  [LAT];
    logic [N-1:0] addr_d  [LAT];

    always_comb begin
        // NOTE: every comb output gets a value on every path, so no latch is inferred.
        valid_d[0] = in_valid & ~flush;
        addr_d[0]  = in_addr;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1] & ~flush;
            addr_d[i]  = addr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: addresses are reset as well as valids so wb_addr reads 0 out of reset.
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking updates let every stage sample its neighbour's old value.
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= valid_d[i];
                addr_q[i]  <= addr_d[i];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/wb_dest_scoreboard.sv
// Destination select, busy scoreboard and RAW/WAW issue stall between decode
// and the register-file write port.
module wb_dest_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned LINK_REG = DEFAULT_LINK_REG,
    parameter int unsigned LAT      = DEFAULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [1:0]        M2,
    input  logic [N-1:0]      rt,
    input  logic [N-1:0]      rd,
    input  logic [N-1:0]      src_a,
    input  logic [N-1:0]      src_b,
    input  logic              src_a_used,
    input  logic              src_b_used,
    output logic              issue_stall,
    output logic [N-1:0]      Reg_write_ad,
    output logic              wb_valid,
    output logic [N-1:0]      wb_addr,
    output logic [2**N-1:0]   busy_vec,
    output logic [3:0]        inflight
);

    localparam int unsigned NREG = 2**N;

    logic            has_dest;
    logic            hazard;
    logic            accept;
    logic            accept_dest;
    logic [NREG-1:0] eff_busy;
    logic [NREG-1:0] dest_onehot;
    logic [NREG-1:0] busy_vec_q, busy_vec_d;
    logic [3:0]      inflight_q, inflight_d;

    always_comb begin
        Reg_write_ad = '0;
        case (M2)
            DST_LINK: Reg_write_ad = N'(LINK_REG);
            DST_RT:   Reg_write_ad = rt;
            DST_RD:   Reg_write_ad = rd;
            default:  Reg_write_ad = '0;
        endcase
    end

    assign has_dest = (M2 != DST_NONE);

    // A register retiring this cycle is written now, so it no longer blocks issue.
    always_comb begin
        eff_busy = busy_vec_q;
        if (wb_valid) begin
            eff_busy[wb_addr] = 1'b0;
        end
        hazard = (src_a_used & eff_busy[src_a])
               | (src_b_used & eff_busy[src_b])
               | (has_dest   & eff_busy[Reg_write_ad]);
    end

    assign issue_stall = issue_valid & ~flush & hazard;
    assign accept      = issue_valid & ~flush & ~hazard;
    assign accept_dest = accept & has_dest;

    always_comb begin
        dest_onehot = '0;
        if (accept_dest) begin
            dest_onehot[Reg_write_ad] = 1'b1;
        end
        busy_vec_d = eff_busy | dest_onehot;
        inflight_d = inflight_q + 4'(accept_dest) - 4'(wb_valid);
        if (flush) begin
            busy_vec_d = '0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec_q <= '0;
            inflight_q <= '0;
        end else begin
            busy_vec_q <= busy_vec_d;
            inflight_q <= inflight_d;
        end
    end

    wb_delay_line #(
        .N   (N),
        .LAT (LAT)
    ) u_delay_line (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (accept_dest),
        .in_addr   (Reg_write_ad),
        .out_valid (wb_valid),
        .out_addr  (wb_addr)
    );

    assign busy_vec = busy_vec_q;
    assign inflight = inflight_q;

endmodule
